// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage: a clk prescaler feeds an 8-bit period counter, and
// each pin is off, on, or follows one shared duty level. Optional macro: PWM_SHADOW_EN.
module pwm_peripheral #(
  parameter int unsigned DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic [15:0] pre_cnt;
  logic        tick;
  logic [7:0]  pwm_cnt;
  logic        wrap;
  logic [7:0]  active_duty;
  logic        level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;

  assign tick = (pre_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_cnt <= 16'd0;
    else if (tick)
      pre_cnt <= 16'd0;
    else
      pre_cnt <= pre_cnt + 16'd1;
  end

  // The counter wraps 255 -> 0 on its own; wrap marks that edge.
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_cnt <= 8'd0;
    else if (tick)
      pwm_cnt <= pwm_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      period_start <= 1'b0;
    else
      period_start <= wrap;
  end

`ifdef PWM_SHADOW_EN
  // Duty only changes at a period boundary, so every period is well formed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      active_duty <= 8'h00;
    else if (wrap)
      active_duty <= pwm_duty_cycle;
  end
`else
  assign active_duty = pwm_duty_cycle;
`endif

  // 0xFF is special-cased so the top duty value is a true 100%.
  assign level = (active_duty == 8'hFF) || (pwm_cnt < active_duty);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    out_next = en_out & (~en_pwm | {16{level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out <= 16'h0000;
    else
      out <= out_next;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration registers produced by the SPI register-write block and drives 16 output pins. Each pin is off, statically on, or driven by one shared 8-bit PWM waveform. Timebase is a clk prescaler feeding an 8-bit period counter; nominal period is about 3 kHz at clk = 10 MHz. Sits directly downstream of the SPI peripheral; outputs go straight to the chip output pads.

Parameters:
DIV, 13, prescaler divide ratio in clk cycles per PWM tick; legal range 1..65535; PWM period = DIV*256 clk cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM select, pins 7..0
en_reg_pwm_15_8  input  8  PWM select, pins 15..8
pwm_duty_cycle  input  8  duty value, 0x00..0xFF
out  output  16  registered pin drive
period_start  output  1  one-clk pulse at the start of each PWM period

Behaviour:
- Reset (async assert, sync-style deassert by rst_n high at a clk edge):
  - out = 16'h0000.
  - period_start = 0.
  - Prescaler count = 0.
  - PWM counter = 0.
  - Active duty = 0x00.
- Prescaler: counts 0..DIV-1 on every clk.
  - tick = 1 in the cycle the count equals DIV-1; the count then returns to 0.
  - DIV=1 gives tick every cycle.
- PWM counter: 8-bit, advances only on tick, wraps 255 -> 0 with no stall.
- period_start: registered.
  - High for exactly one clk on the edge where the PWM counter goes 255 -> 0.
  - Low in all other cycles.
  - Not asserted on reset release.
- PWM level, combinational:
  - duty == 0xFF -> 1 for the whole period (true 100%).
  - Otherwise level = (pwm_cnt < duty).
  - duty 0x00 -> constant 0.
  - duty N (1..254) -> high for N ticks = N*DIV clk at the start of each period, low for the remaining (256-N)*DIV clk.
- Per pin i (enable vectors formed as {en_*_15_8, en_*_7_0}):
  - en_out[i]=0 -> next out[i] = 0, regardless of en_pwm[i].
  - en_out[i]=1 and en_pwm[i]=0 -> next out[i] = 1.
  - en_out[i]=1 and en_pwm[i]=1 -> next out[i] = PWM level.
- Latency:
  - out is registered, so any enable change or PWM level change appears on out one clk edge later.
  - No glitches on out.
- Inputs are treated as synchronous to clk; the upstream block writes them in the clk domain, so no synchronizers are needed.
- Duty source, without the optional feature: pwm_duty_cycle is used live each cycle.
  - A mid-period duty change takes effect on the next level evaluation.
  - This can yield one irregular pulse.
- Reset mid-operation: out drops to 0 immediately (asynchronous), and all counters restart from 0.

Optional Feature:
Macro PWM_SHADOW_EN.
- Defined:
  - An 8-bit active-duty shadow register is loaded from pwm_duty_cycle only on the clk edge where period_start is asserted, i.e. the counter wraps to 0.
  - PWM level uses the shadow register, so a duty write never changes the current period.
  - The shadow resets to 0x00, so outputs in PWM mode stay low until the first period boundary after reset, even if duty is nonzero.
- Not defined:
  - No shadow register; live duty as described above.
  - Ports are identical in both builds.

Test Plan:
1. Reset: assert rst_n=0 mid-run with out=16'hFFFF -> out=0 and period_start=0 immediately, before any clk edge. After release, the first period_start appears at clk DIV*256 (3328 with DIV=13).
2. Static enables: en_out=16'hA5C3, en_pwm=0, duty=0x80 -> out=16'hA5C3 one clk after the inputs are applied and constant thereafter. en_out=0 with en_pwm=16'hFFFF -> out=0.
3. PWM 50%: DIV=13, en_out bit 0 and en_pwm bit 0 set, duty=0x80 -> out[0] high 1664 clk and low 1664 clk per 3328-clk period. The rising edge of out[0] is one clk after the period_start edge.
4. Duty boundaries:
   - duty=0x00 -> out[0] constant 0 over 2 periods.
   - duty=0xFF -> constant 1 over 2 periods.
   - duty=0x01 -> high exactly 13 clk per period.
5. Mixed pins: en_out=16'hFFFF, en_pwm=16'h00FF, duty=0x40 -> out[15:8] constant 1. out[7:0] all toggle together, high 832 clk per 3328-clk period.
6. Duty change mid-period (duty 0x40 -> 0xC0 written at tick 100):
   - With PWM_SHADOW_EN: the current period stays low from tick 64; the next period is high 192 ticks.
   - Without it: out[0] goes high again within 1 clk of the write and stays high until tick 192.
